// File: rtl/intr_sched_pkg.sv
// -----------------------------------------------------------------------------
// intr_sched_pkg
// Shared types and constants for the interrupt priority scheduler.
//   - NSRC_DEF / VW_DEF : default source count and vector width
//   - level_t           : 2-bit priority level (0 = never delivered, 3 = highest)
//   - REG_*             : io register window addresses
//   - sched_state_t     : scheduler FSM states
//   - dbg_t             : debug view of the scheduler (FSM state, picker levels)
// -----------------------------------------------------------------------------
package intr_sched_pkg;

    localparam int NSRC_DEF = 5;
    localparam int VW_DEF   = 3;

    typedef logic [1:0] level_t;

    localparam logic [3:0] REG_PRIO   = 4'd0;
    localparam logic [3:0] REG_ISR    = 4'd1;
    localparam logic [3:0] REG_EOI    = 4'd2;
    localparam logic [3:0] REG_STAT   = 4'd3;
    localparam logic [3:0] REG_THRESH = 4'd4;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } sched_state_t;

    typedef struct packed {
        sched_state_t state;
        level_t       best_level;
        level_t       eoi_level;
    } dbg_t;

    function automatic level_t max_level(input level_t a, input level_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/intr_sched_if.sv
// -----------------------------------------------------------------------------
// intr_sched_if
// Bundles the scheduler's pending input, CPU request/ack handshake and the
// 16-bit io register window.
//   slave  modport : the scheduler (drives cpu_irq, cpu_vec, io_rdata)
//   master modport : the surrounding system (drives pending, cpu_ack, io_*)
//
// Handshake: cpu_irq is the request; while it is high cpu_vec is held stable.
// A single-cycle cpu_ack while cpu_irq=1 completes the transfer on that clock
// edge. cpu_irq may also drop without an ack when the request is withdrawn.
// cpu_ack while cpu_irq=0 has no effect.
// -----------------------------------------------------------------------------
interface intr_sched_if #(
    parameter int NSRC = 5,
    parameter int VW   = 3
);
    logic [NSRC-1:0] pending;
    logic            cpu_irq;
    logic [VW-1:0]   cpu_vec;
    logic            cpu_ack;
    logic            io_write;
    logic [3:0]      io_addr;
    logic [15:0]     io_wdata;
    logic [15:0]     io_rdata;

    modport slave (
        input  pending, cpu_ack, io_write, io_addr, io_wdata,
        output cpu_irq, cpu_vec, io_rdata
    );

    modport master (
        output pending, cpu_ack, io_write, io_addr, io_wdata,
        input  cpu_irq, cpu_vec, io_rdata
    );
endinterface

// File: rtl/intr_prio_pick.sv
// -----------------------------------------------------------------------------
// intr_prio_pick
// Combinational selector: among the sources whose mask bit is set, returns the
// one with the highest level. Equal levels resolve to the first source met
// when scanning upward from the start position (wrapping). With RR=0 the scan
// always starts at source 0; with RR=1 it starts at the one-hot rr_ptr.
//   mask   in  NSRC     sources eligible for selection
//   levels in  2*NSRC   level of source i at [2i+1:2i]
//   rr_ptr in  NSRC     one-hot scan start (only honoured when RR=1)
//   valid  out 1        any mask bit set
//   index  out VW       selected source
//   level  out 2        level of the selected source
// -----------------------------------------------------------------------------
module intr_prio_pick
    import intr_sched_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int VW   = VW_DEF,
    parameter bit RR   = 1'b0
) (
    input  logic [NSRC-1:0]   mask,
    input  logic [2*NSRC-1:0] levels,
    input  logic [NSRC-1:0]   rr_ptr,
    output logic              valid,
    output logic [VW-1:0]     index,
    output level_t            level
);

    int start_idx;

    always_comb begin
        start_idx = 0;
        for (int i = 0; i < NSRC; i++) begin
            if (rr_ptr[i]) start_idx = i;
        end
        if (!RR) start_idx = 0;
    end

    // Strict '>' keeps the first source met in scan order on level ties.
    always_comb begin
        valid = 1'b0;
        index = '0;
        level = '0;
        for (int k = 0; k < NSRC; k++) begin
            int j;
            j = start_idx + k;
            if (j >= NSRC) j = j - NSRC;
            if (mask[j] && (!valid || (levels[2*j +: 2] > level))) begin
                valid = 1'b1;
                index = VW'(j);
                level = levels[2*j +: 2];
            end
        end
    end

endmodule

// File: rtl/intr_sched.sv
// -----------------------------------------------------------------------------
// intr_sched
// Priority scheduler between the interrupt controller's pending vector and the
// CPU. Picks the best eligible source, presents it as a frozen vector with a
// req/ack handshake, tracks in-service sources for nesting, and exposes
// PRIO / ISR / EOI / STAT / THRESH through a 16-bit register window.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of intr_sched_if (pending, cpu_irq/cpu_vec/cpu_ack,
//          io_write/io_addr/io_wdata/io_rdata)
//   dbg    out  FSM state plus the two picker levels
//
// Build option: define INTR_SCHED_RR_EN to resolve equal-level ties round-robin
// (pointer moves just past each acked source). Undefined: ties go to the
// lowest index. EOI target selection is always lowest-index on ties.
// -----------------------------------------------------------------------------
module intr_sched
    import intr_sched_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int VW   = VW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    intr_sched_if.slave    bus,
    output dbg_t           dbg
);

    logic [2*NSRC-1:0] prio_q;
    logic [NSRC-1:0]   isr_q;
    level_t            thresh_q;
    sched_state_t      state_q, state_d;
    logic [VW-1:0]     vec_q;

    level_t            running_level;
    level_t            floor_level;
    logic [NSRC-1:0]   cand;
    logic              best_valid;
    logic [VW-1:0]     best_idx;
    level_t            best_lvl;
    logic              eoi_valid;
    logic [VW-1:0]     eoi_idx;
    level_t            eoi_lvl;
    logic              ack_take;
    logic              withdraw;
    logic              eoi_wr;
    logic [NSRC-1:0]   eoi_mask;
    logic [NSRC-1:0]   ack_mask;
    logic [NSRC-1:0]   rr_ptr_q;

`ifdef INTR_SCHED_RR_EN
    localparam bit RR_ON = 1'b1;
    logic [NSRC-1:0] rr_ptr_next;
    int              rr_pos;

    always_comb begin
        rr_pos = int'(vec_q) + 1;
        if (rr_pos >= NSRC) rr_pos = 0;
        rr_ptr_next = NSRC'(1) << rr_pos;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= NSRC'(1);
        end else if (ack_take) begin
            rr_ptr_q <= rr_ptr_next;
        end
    end
`else
    localparam bit RR_ON = 1'b0;
    assign rr_ptr_q = NSRC'(1);
`endif

    // Highest level currently in service; it and THRESH set the bar to beat.
    always_comb begin
        running_level = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (isr_q[i]) running_level = max_level(running_level, prio_q[2*i +: 2]);
        end
        floor_level = max_level(running_level, thresh_q);
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            cand[i] = bus.pending[i] && !isr_q[i] && (prio_q[2*i +: 2] > floor_level);
        end
    end

    intr_prio_pick #(.NSRC(NSRC), .VW(VW), .RR(RR_ON)) u_best (
        .mask   (cand),
        .levels (prio_q),
        .rr_ptr (rr_ptr_q),
        .valid  (best_valid),
        .index  (best_idx),
        .level  (best_lvl)
    );

    intr_prio_pick #(.NSRC(NSRC), .VW(VW), .RR(1'b0)) u_eoi (
        .mask   (isr_q),
        .levels (prio_q),
        .rr_ptr (rr_ptr_q),
        .valid  (eoi_valid),
        .index  (eoi_idx),
        .level  (eoi_lvl)
    );

    // Request-side events. Ack wins over a simultaneous withdraw.
    assign ack_take = (state_q == REQ) && bus.cpu_ack;
    assign withdraw = (state_q == REQ) && !bus.cpu_ack &&
                      (!bus.pending[vec_q] || (prio_q[2*vec_q +: 2] <= floor_level));
    assign eoi_wr   = bus.io_write && (bus.io_addr == REG_EOI);
    assign eoi_mask = (eoi_wr && eoi_valid) ? (NSRC'(1) << eoi_idx) : '0;
    assign ack_mask = ack_take ? (NSRC'(1) << vec_q) : '0;

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state. The vector is frozen in REQ; no re-arbitration there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (best_valid) state_d = REQ;
            REQ:     if (ack_take || withdraw) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.cpu_irq = (state_q == REQ);
        bus.cpu_vec = vec_q;
        dbg.state      = state_q;
        dbg.best_level = best_lvl;
        dbg.eoi_level  = eoi_lvl;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec_q <= '0;
        end else if ((state_q == IDLE) && best_valid) begin
            vec_q <= best_idx;
        end
    end

    // EOI target comes from the old ISR; the acked bit is then OR-ed in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            isr_q <= '0;
        end else begin
            isr_q <= (isr_q & ~eoi_mask) | ack_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q   <= '0;
            thresh_q <= '0;
        end else if (bus.io_write) begin
            if (bus.io_addr == REG_PRIO)   prio_q   <= bus.io_wdata[2*NSRC-1:0];
            if (bus.io_addr == REG_THRESH) thresh_q <= bus.io_wdata[1:0];
        end
    end

    always_comb begin
        case (bus.io_addr)
            REG_PRIO:   bus.io_rdata = 16'(prio_q);
            REG_ISR:    bus.io_rdata = 16'(isr_q);
            REG_STAT:   bus.io_rdata = 16'({bus.cpu_irq, 4'b0000, running_level, thresh_q, vec_q});
            REG_THRESH: bus.io_rdata = 16'(thresh_q);
            default:    bus.io_rdata = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_intr_sched.sv
// -----------------------------------------------------------------------------
// tb_intr_sched
// Self-checking bench for intr_sched: directed scenarios plus a randomized run
// checked against a behavioural model of the scheduling rules.
// -----------------------------------------------------------------------------
module tb_intr_sched;
    import intr_sched_pkg::*;

    localparam int NSRC = 5;
    localparam int VW   = 3;
`ifdef INTR_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    dbg_t dbg;

    always #5 clk = ~clk;

    intr_sched_if #(.NSRC(NSRC), .VW(VW)) bus ();

    intr_sched #(.NSRC(NSRC), .VW(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .dbg   (dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural model ----------------
    int            m_prio [NSRC];
    bit [NSRC-1:0] m_isr;
    int            m_thr;
    bit            m_req;
    int            m_vec;
    int            m_ptr;

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) m_prio[i] = 0;
        m_isr = '0;
        m_thr = 0;
        m_req = 0;
        m_vec = 0;
        m_ptr = 0;
    endtask

    function automatic int m_running();
        int r = 0;
        for (int i = 0; i < NSRC; i++)
            if (m_isr[i] && m_prio[i] > r) r = m_prio[i];
        return r;
    endfunction

    function automatic int m_floor();
        int r = m_running();
        return (m_thr > r) ? m_thr : r;
    endfunction

    // highest level in mask; ties go to the first hit scanning up from start
    function automatic int m_pick(input bit [NSRC-1:0] mask, input int start);
        int bi = -1;
        int bl = -1;
        for (int k = 0; k < NSRC; k++) begin
            int i = (start + k) % NSRC;
            if (mask[i] && m_prio[i] > bl) begin
                bl = m_prio[i];
                bi = i;
            end
        end
        return bi;
    endfunction

    function automatic logic [15:0] model_read(input int addr);
        int v = 0;
        case (addr)
            0: for (int i = 0; i < NSRC; i++) v += m_prio[i] << (2 * i);
            1: v = int'(m_isr);
            3: v = (int'(m_req) << 11) + (m_running() << 5) + (m_thr << 3) + m_vec;
            4: v = m_thr;
            default: v = 0;
        endcase
        return 16'(v);
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        int            fl  = m_floor();
        bit [NSRC-1:0] cm;
        bit [NSRC-1:0] nisr = m_isr;
        int            eoi_t = -1;
        int            b;
        for (int i = 0; i < NSRC; i++)
            cm[i] = bus.pending[i] && !m_isr[i] && (m_prio[i] > fl);
        if (bus.io_write && bus.io_addr == 4'd2) eoi_t = m_pick(m_isr, 0);
        b = m_pick(cm, RR ? m_ptr : 0);
        if (eoi_t >= 0) nisr[eoi_t] = 1'b0;
        if (m_req) begin
            if (bus.cpu_ack) begin
                nisr[m_vec] = 1'b1;
                m_ptr = (m_vec + 1) % NSRC;
                m_req = 0;
            end else if (!bus.pending[m_vec] || m_prio[m_vec] <= fl) begin
                m_req = 0;
            end
        end else if (b >= 0) begin
            m_req = 1;
            m_vec = b;
        end
        m_isr = nisr;
        if (bus.io_write && bus.io_addr == 4'd0)
            for (int i = 0; i < NSRC; i++) m_prio[i] = int'(bus.io_wdata[2*i +: 2]);
        if (bus.io_write && bus.io_addr == 4'd4) m_thr = int'(bus.io_wdata[1:0]);
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [15:0] data);
        bus.io_write = 1'b1;
        bus.io_addr  = addr;
        bus.io_wdata = data;
        step();
        bus.io_write = 1'b0;
        bus.io_wdata = 16'h0000;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.pending  = 5'h1f;
        bus.cpu_ack  = 1'b0;
        bus.io_write = 1'b0;
        bus.io_addr  = 4'd0;
        bus.io_wdata = 16'h0000;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            n_tests++;
            if (bus.cpu_irq !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_irq cycle %0d: got %b want 0", c, bus.cpu_irq);
            end
        end
        for (int a = 0; a < 16; a++) begin
            bus.io_addr = 4'(a);
            #1;
            n_tests++;
            if (bus.io_rdata !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_read addr %0d: got %h want 0000", a, bus.io_rdata);
            end
        end
        bus.pending = '0;
        step();
    endtask

    task automatic test_basic();
        do_write(4'd0, 16'h0008);
        bus.pending = 5'b00010;
        step();
        n_tests++;
        if (bus.cpu_irq !== 1'b1 || bus.cpu_vec !== 3'd1) begin
            n_fail++;
            $display("FAIL basic_req: got irq=%b vec=%0d want irq=1 vec=1", bus.cpu_irq, bus.cpu_vec);
        end
        bus.cpu_ack = 1'b1;
        step();
        bus.cpu_ack = 1'b0;
        bus.io_addr = 4'd1;
        #1;
        n_tests++;
        if (bus.cpu_irq !== 1'b0 || bus.io_rdata !== 16'h0002) begin
            n_fail++;
            $display("FAIL basic_ack: got irq=%b isr=%h want irq=0 isr=0002", bus.cpu_irq, bus.io_rdata);
        end
    endtask

    task automatic test_nesting();
        do_write(4'd0, 16'h0348);
        bus.pending = 5'b01000;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (bus.cpu_irq !== 1'b0) begin
                n_fail++;
                $display("FAIL nest_low cycle %0d: got irq=%b want 0", c, bus.cpu_irq);
            end
        end
        bus.pending = 5'b11000;
        step();
        n_tests++;
        if (bus.cpu_irq !== 1'b1 || bus.cpu_vec !== 3'd4) begin
            n_fail++;
            $display("FAIL nest_high: got irq=%b vec=%0d want irq=1 vec=4", bus.cpu_irq, bus.cpu_vec);
        end
        bus.cpu_ack = 1'b1;
        step();
        bus.cpu_ack = 1'b0;
        bus.pending = '0;
        bus.io_addr = 4'd1;
        #1;
        n_tests++;
        if (bus.io_rdata !== 16'h0012) begin
            n_fail++;
            $display("FAIL nest_isr: got %h want 0012", bus.io_rdata);
        end
        do_write(4'd2, 16'h0000);
        bus.io_addr = 4'd1;
        #1;
        n_tests++;
        if (bus.io_rdata !== 16'h0002) begin
            n_fail++;
            $display("FAIL nest_eoi1: got %h want 0002", bus.io_rdata);
        end
        do_write(4'd2, 16'h0000);
        bus.io_addr = 4'd1;
        #1;
        n_tests++;
        if (bus.io_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL nest_eoi2: got %h want 0000", bus.io_rdata);
        end
        do_write(4'd2, 16'h0000);
        bus.io_addr = 4'd1;
        #1;
        n_tests++;
        if (bus.io_rdata !== 16'h0000 || bus.cpu_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL nest_eoi_empty: got isr=%h irq=%b want 0000 0", bus.io_rdata, bus.cpu_irq);
        end
    endtask

    task automatic test_withdraw();
        do_write(4'd0, 16'h0001);
        bus.pending = 5'b00001;
        step();
        n_tests++;
        if (bus.cpu_irq !== 1'b1 || bus.cpu_vec !== 3'd0) begin
            n_fail++;
            $display("FAIL wd_req: got irq=%b vec=%0d want 1 0", bus.cpu_irq, bus.cpu_vec);
        end
        bus.pending = '0;
        step();
        bus.io_addr = 4'd1;
        #1;
        n_tests++;
        if (bus.cpu_irq !== 1'b0 || bus.io_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL wd_drop: got irq=%b isr=%h want 0 0000", bus.cpu_irq, bus.io_rdata);
        end
        bus.pending = 5'b00001;
        step();
        n_tests++;
        if (bus.cpu_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_req2: got irq=%b want 1", bus.cpu_irq);
        end
        bus.pending = '0;
        bus.cpu_ack = 1'b1;
        step();
        bus.cpu_ack = 1'b0;
        #1;
        n_tests++;
        if (bus.cpu_irq !== 1'b0 || bus.io_rdata !== 16'h0001) begin
            n_fail++;
            $display("FAIL wd_ack_wins: got irq=%b isr=%h want 0 0001", bus.cpu_irq, bus.io_rdata);
        end
        bus.cpu_ack = 1'b1;
        step();
        bus.cpu_ack = 1'b0;
        #1;
        n_tests++;
        if (bus.cpu_irq !== 1'b0 || bus.io_rdata !== 16'h0001) begin
            n_fail++;
            $display("FAIL idle_ack: got irq=%b isr=%h want 0 0001", bus.cpu_irq, bus.io_rdata);
        end
        do_write(4'd2, 16'h0000);
    endtask

    task automatic test_threshold();
        do_write(4'd0, 16'h0020);
        do_write(4'd4, 16'h0002);
        bus.pending = 5'b00100;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (bus.cpu_irq !== 1'b0) begin
                n_fail++;
                $display("FAIL thr_block cycle %0d: got irq=%b want 0", c, bus.cpu_irq);
            end
        end
        bus.io_addr = 4'd3;
        #1;
        n_tests++;
        if (bus.io_rdata !== 16'h0010) begin
            n_fail++;
            $display("FAIL thr_stat: got %h want 0010", bus.io_rdata);
        end
        do_write(4'd4, 16'h0000);
        n_tests++;
        if (bus.cpu_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL thr_write_latency: got irq=%b want 0", bus.cpu_irq);
        end
        step();
        n_tests++;
        if (bus.cpu_irq !== 1'b1 || bus.cpu_vec !== 3'd2) begin
            n_fail++;
            $display("FAIL thr_open: got irq=%b vec=%0d want 1 2", bus.cpu_irq, bus.cpu_vec);
        end
        bus.cpu_ack = 1'b1;
        step();
        bus.cpu_ack = 1'b0;
        do_write(4'd0, 16'h002d);
        bus.pending = 5'b00110;
        step();
        n_tests++;
        if (bus.cpu_irq !== 1'b1 || bus.cpu_vec !== 3'd1) begin
            n_fail++;
            $display("FAIL same_req: got irq=%b vec=%0d want 1 1", bus.cpu_irq, bus.cpu_vec);
        end
        bus.cpu_ack  = 1'b1;
        bus.io_write = 1'b1;
        bus.io_addr  = 4'd2;
        step();
        bus.cpu_ack  = 1'b0;
        bus.io_write = 1'b0;
        bus.io_addr  = 4'd1;
        #1;
        n_tests++;
        if (bus.io_rdata !== 16'h0002) begin
            n_fail++;
            $display("FAIL same_eoi_ack: got isr=%h want 0002", bus.io_rdata);
        end
        bus.io_addr = 4'd3;
        #1;
        n_tests++;
        if (bus.io_rdata !== 16'h0061) begin
            n_fail++;
            $display("FAIL same_stat: got %h want 0061", bus.io_rdata);
        end
        bus.pending = '0;
        do_write(4'd2, 16'h0000);
    endtask

    task automatic test_async_reset();
        do_write(4'd0, 16'h0001);
        bus.pending = 5'b00001;
        step();
        n_tests++;
        if (bus.cpu_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_req: got irq=%b want 1", bus.cpu_irq);
        end
        #2;
        reset = 1'b0;
        #1;
        bus.io_addr = 4'd0;
        #1;
        n_tests++;
        if (bus.cpu_irq !== 1'b0 || bus.io_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL arst_drop: got irq=%b prio=%h want 0 0000", bus.cpu_irq, bus.io_rdata);
        end
        bus.pending = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_rr();
        do_write(4'd0, 16'h0011);
        bus.pending = 5'b00101;
        for (int k = 0; k < 4; k++) begin
            int w = 0;
            int exp_vec = (RR && (k % 2 == 1)) ? 2 : 0;
            while (bus.cpu_irq !== 1'b1 && w < 10) begin
                step();
                w++;
            end
            n_tests++;
            if (bus.cpu_irq !== 1'b1 || int'(bus.cpu_vec) != exp_vec) begin
                n_fail++;
                $display("FAIL rr_vec round %0d: got irq=%b vec=%0d want 1 %0d", k, bus.cpu_irq, bus.cpu_vec, exp_vec);
            end
            bus.cpu_ack = 1'b1;
            step();
            bus.cpu_ack = 1'b0;
            do_write(4'd2, 16'h0000);
        end
        bus.pending = '0;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int r = $urandom_range(0, 9);
            logic [15:0] exp_rd;
            bus.pending  = NSRC'($urandom);
            bus.cpu_ack  = ($urandom_range(0, 2) == 0);
            bus.io_write = 1'b0;
            bus.io_wdata = 16'($urandom);
            bus.io_addr  = 4'($urandom_range(0, 15));
            case (r)
                0: begin bus.io_write = 1'b1; bus.io_addr = 4'd0; end
                1: begin bus.io_write = 1'b1; bus.io_addr = 4'd4; end
                2, 3: begin bus.io_write = 1'b1; bus.io_addr = 4'd2; end
                4: bus.io_write = 1'b1;
                default: ;
            endcase
            exp_rd = model_read(int'(bus.io_addr));
            #1;
            n_tests++;
            if (bus.io_rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL rand_read cycle %0d addr %0d: got %h want %h", c, bus.io_addr, bus.io_rdata, exp_rd);
            end
            step();
            n_tests++;
            if (bus.cpu_irq !== m_req || int'(bus.cpu_vec) != m_vec) begin
                n_fail++;
                $display("FAIL rand_irq cycle %0d: got irq=%b vec=%0d want irq=%b vec=%0d", c, bus.cpu_irq, bus.cpu_vec, m_req, m_vec);
            end
        end
        bus.io_write = 1'b0;
        bus.cpu_ack  = 1'b0;
        bus.pending  = '0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_basic();
        test_nesting();
        test_withdraw();
        test_threshold();
        test_async_reset();
        test_rr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
